// File: rtl/datapath_seq.sv
// datapath_seq: five-state sequencer around a 16-bit shifter/ALU datapath.
// An operation reads two operands from an external register file, one per
// cycle (RD_A, RD_B). It then computes C and the {V,N,Z} flags (EXEC) and
// optionally writes C back (WB). Completion is signalled by a one-cycle
// done pulse.
module datapath_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  alu_op,
  input  logic [1:0]  shift,
  input  logic [2:0]  rn,
  input  logic [2:0]  rm,
  input  logic [2:0]  rd,
  input  logic        wb_en,
  input  logic [15:0] rf_data_out,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic [15:0] data_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic [2:0]  status
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_A,
    S_RD_B,
    S_EXEC,
    S_WB
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_NOT = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL1 = 2'b01,
    SH_LSR1 = 2'b10,
    SH_ASR1 = 2'b11
  } shift_t;

  state_t      state_q;

  // Operation fields captured at acceptance; they stay stable while busy.
  alu_op_t     op_q;
  shift_t      shift_q;
  logic [2:0]  rn_q;
  logic [2:0]  rm_q;
  logic [2:0]  rd_q;
  logic        wb_en_q;

  // Datapath registers.
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [15:0] c_q;
  logic [2:0]  status_q;

  // Registered control outputs.
  logic [2:0]  readnum_q;
  logic [2:0]  writenum_q;
  logic        write_q;
  logic        busy_q;
  logic        done_q;

  // Next-state values produced by the shifter/ALU.
  logic [15:0] b_shift_d;
  logic [15:0] c_d;
  logic        v_d;
  logic [2:0]  status_d;

  // Shifter on B followed by the ALU and flag generation.
  always_comb begin
    // NOTE: every variable gets a default before the case statements, so
    // no path leaves a value unassigned and no latch is inferred.
    b_shift_d = b_q;
    c_d       = '0;
    v_d       = 1'b0;

    case (shift_q)
      SH_NONE: b_shift_d = b_q;
      SH_LSL1: b_shift_d = {b_q[14:0], 1'b0};
      SH_LSR1: b_shift_d = {1'b0, b_q[15:1]};
      SH_ASR1: b_shift_d = {b_q[15], b_q[15:1]};
      default: b_shift_d = b_q;
    endcase

    case (op_q)
      OP_ADD: begin
        c_d = a_q + b_shift_d;
        v_d = (a_q[15] == b_shift_d[15]) && (c_d[15] != a_q[15]);
      end
      OP_SUB: begin
        c_d = a_q - b_shift_d;
        v_d = (a_q[15] != b_shift_d[15]) && (c_d[15] != a_q[15]);
      end
      OP_AND: c_d = a_q & b_shift_d;
      OP_NOT: c_d = ~b_shift_d;
      default: c_d = '0;
    endcase

    status_d = {v_d, c_d[15], (c_d == 16'h0000)};
  end

  // Sequencer: state, captured fields, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments, so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= OP_ADD;
      shift_q    <= SH_NONE;
      rn_q       <= '0;
      rm_q       <= '0;
      rd_q       <= '0;
      wb_en_q    <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      status_q   <= '0;
      readnum_q  <= '0;
      writenum_q <= '0;
      write_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q      <= alu_op_t'(alu_op);
            shift_q   <= shift_t'(shift);
            rn_q      <= rn;
            rm_q      <= rm;
            rd_q      <= rd;
            wb_en_q   <= wb_en;
            readnum_q <= rn;
            busy_q    <= 1'b1;
            state_q   <= S_RD_A;
          end
        end
        S_RD_A: begin
          a_q       <= rf_data_out;
          readnum_q <= rm_q;
          state_q   <= S_RD_B;
        end
        S_RD_B: begin
          b_q       <= rf_data_out;
          readnum_q <= '0;
          state_q   <= S_EXEC;
        end
        S_EXEC: begin
          c_q        <= c_d;
          status_q   <= status_d;
          writenum_q <= rd_q;
          write_q    <= wb_en_q;
          state_q    <= S_WB;
        end
        S_WB: begin
          writenum_q <= '0;
          write_q    <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b1;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // NOTE: write is masked by reset combinationally, because the register
  // file samples it on the same edge that reset would otherwise be too late for.
  assign write    = write_q & ~reset;
  assign readnum  = readnum_q;
  assign writenum = writenum_q;
  assign data_in  = c_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = c_q;
  assign status   = status_q;

endmodule

// File: tb/tb_datapath_seq.sv
// tb_datapath_seq: drives datapath_seq against an 8x16 register file model.
// A behavioural reference (integer arithmetic over a shadow register array)
// predicts every result, flag set and register file write.
module tb_datapath_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  alu_op;
  logic [1:0]  shift;
  logic [2:0]  rn;
  logic [2:0]  rm;
  logic [2:0]  rd;
  logic        wb_en;
  logic [15:0] rf_data_out;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic [15:0] data_in;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [2:0]  status;

  int checks   = 0;
  int failures = 0;

  // Register file environment plus a preload port used only by the bench.
  logic [15:0] rf [8];
  logic        pl_en;
  logic [2:0]  pl_addr;
  logic [15:0] pl_data;

  // Shadow register contents predicted by the reference model.
  int          ref_rf [8];

  datapath_seq dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .alu_op      (alu_op),
    .shift       (shift),
    .rn          (rn),
    .rm          (rm),
    .rd          (rd),
    .wb_en       (wb_en),
    .rf_data_out (rf_data_out),
    .readnum     (readnum),
    .writenum    (writenum),
    .write       (write),
    .data_in     (data_in),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .status      (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: DUT write port has priority over the bench preload port.
  always @(posedge clk) begin
    if (write) rf[writenum] <= data_in;
    else if (pl_en) rf[pl_addr] <= pl_data;
  end

  assign rf_data_out = rf[readnum];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: returns {V,N,Z, C[15:0]} from the operation's arithmetic definition.
  function automatic logic [18:0] model(input int op, input int sh, input int a, input int b);
    int sb, sa_s, sb_s, r, c;
    logic v, n, z;
    logic [15:0] c16;
    case (sh)
      0:       sb = b;
      1:       sb = (b * 2) % 65536;
      2:       sb = b / 2;
      default: sb = b / 2 + ((b >= 32768) ? 32768 : 0);
    endcase
    sa_s = (a  >= 32768) ? a  - 65536 : a;
    sb_s = (sb >= 32768) ? sb - 65536 : sb;
    v = 1'b0;
    case (op)
      0: begin r = sa_s + sb_s; v = (r > 32767) || (r < -32768); end
      1: begin r = sa_s - sb_s; v = (r > 32767) || (r < -32768); end
      2: r = a & sb;
      default: r = 65535 - sb;
    endcase
    c   = r & 65535;
    c16 = c[15:0];
    n   = (c >= 32768);
    z   = (c == 0);
    return {v, n, z, c16};
  endfunction

  // Load one register through the preload port; starts and ends at a negedge.
  task automatic preload(input int addr, input int value);
    pl_en   = 1'b1;
    pl_addr = addr[2:0];
    pl_data = value[15:0];
    @(posedge clk);
    @(negedge clk);
    pl_en = 1'b0;
    ref_rf[addr] = value;
  endtask

  // One full operation with per-state checks. Starts at a negedge with the DUT
  // in IDLE and ends at the negedge of the done cycle. If rst_in_wb is set,
  // reset (with a coincident start) is asserted during WB instead.
  task automatic run_op(input int op, input int sh, input int a, input int b,
                        input int d, input logic we, input logic rst_in_wb);
    logic [18:0] exp;
    int          before_d;
    exp      = model(op, sh, ref_rf[a], ref_rf[b]);
    before_d = ref_rf[d];

    check("idle_busy", busy, 0);
    start  = 1'b1;
    alu_op = op[1:0];
    shift  = sh[1:0];
    rn     = a[2:0];
    rm     = b[2:0];
    rd     = d[2:0];
    wb_en  = we;
    @(posedge clk);
    @(negedge clk);
    // RD_A; scramble inputs to show they are ignored while busy.
    start  = 1'($urandom_range(0, 1));
    alu_op = 2'($urandom);
    shift  = 2'($urandom);
    rn     = 3'($urandom);
    rm     = 3'($urandom);
    rd     = 3'($urandom);
    wb_en  = 1'($urandom);
    check("rda_busy", busy, 1);
    check("rda_readnum", readnum, a);
    check("rda_write", write, 0);
    check("rda_done", done, 0);
    @(posedge clk);
    @(negedge clk);
    check("rdb_readnum", readnum, b);
    check("rdb_write", write, 0);
    @(posedge clk);
    @(negedge clk);
    check("exec_readnum", readnum, 0);
    check("exec_write", write, 0);
    @(posedge clk);
    @(negedge clk);
    check("wb_writenum", writenum, d);
    check("wb_write", write, we);
    check("wb_readnum", readnum, 0);
    check("wb_data_in", data_in, exp[15:0]);
    check("wb_result", result, exp[15:0]);
    check("wb_status", status, exp[18:16]);
    check("wb_busy", busy, 1);
    start = 1'b0;
    if (rst_in_wb) begin
      reset = 1'b1;
      start = 1'b1;
      #1;
      check("rstwb_write_masked", write, 0);
    end
    @(posedge clk);
    @(negedge clk);
    if (rst_in_wb) begin
      reset = 1'b0;
      start = 1'b0;
      check("rstwb_done", done, 0);
      check("rstwb_busy", busy, 0);
      check("rstwb_write", write, 0);
      check("rstwb_result", result, 0);
      check("rstwb_status", status, 0);
      check("rstwb_writenum", writenum, 0);
      check("rstwb_rf", rf[d], before_d);
    end else begin
      check("done_pulse", done, 1);
      check("done_busy", busy, 0);
      check("done_write", write, 0);
      if (we) ref_rf[d] = exp[15:0];
      check("rf_dest", rf[d], ref_rf[d]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    alu_op = '0;
    shift  = '0;
    rn     = '0;
    rm     = '0;
    rd     = '0;
    wb_en  = 1'b0;
    pl_en  = 1'b0;
    pl_addr = '0;
    pl_data = '0;
    for (int i = 0; i < 8; i++) ref_rf[i] = 0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    // Start coincident with reset must be ignored.
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_write", write, 0);
    check("rst_result", result, 0);
    check("rst_status", status, 0);
    check("rst_readnum", readnum, 0);
    check("rst_writenum", writenum, 0);

    for (int i = 0; i < 8; i++) preload(i, 0);

    // Directed cases.
    preload(0, 5);
    preload(1, 7);
    run_op(0, 0, 0, 1, 2, 1'b1, 1'b0);
    check("add_r2", rf[2], 16'h000C);
    check("add_status", status, 3'b000);
    run_op(1, 0, 0, 1, 3, 1'b1, 1'b0);
    check("sub_r3", rf[3], 16'hFFFE);
    check("sub_status", status, 3'b010);
    preload(4, 16'h7FFF);
    preload(5, 16'h0001);
    run_op(0, 0, 4, 5, 6, 1'b1, 1'b0);
    check("ovf_r6", rf[6], 16'h8000);
    check("ovf_status", status, 3'b110);
    run_op(1, 0, 1, 1, 0, 1'b0, 1'b0);
    check("cmp_status", status, 3'b001);
    check("cmp_r0", rf[0], 5);
    run_op(3, 1, 0, 1, 7, 1'b1, 1'b0);
    check("not_lsl_r7", rf[7], 16'hFFF1);
    preload(4, 16'hFFFF);
    preload(5, 16'h8000);
    run_op(2, 3, 4, 5, 1, 1'b1, 1'b0);
    check("and_asr_r1", rf[1], 16'hC000);

    // Reset during WB of an ADD into R2, then a normal operation.
    run_op(0, 0, 0, 6, 2, 1'b1, 1'b1);
    run_op(0, 0, 0, 6, 2, 1'b1, 1'b0);

    // Randomized operations, mixing back-to-back issue and idle gaps.
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        @(negedge clk);
        check("gap_done", done, 0);
        check("gap_busy", busy, 0);
      end
      run_op(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 7)), 1'($urandom), 1'b0);
    end

    for (int i = 0; i < 8; i++) check("final_rf", rf[i], ref_rf[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/datapath_seq.md
DATAPATH_SEQ -- requirements
Module: datapath_seq

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous, active-high reset sampled on rising edge of clk.
REQ-003 SHALL have port start, input, 1, request to execute one operation; sampled only in IDLE.
REQ-004 SHALL have port alu_op, input, 2, operation: 00 ADD, 01 SUB (A-B), 10 AND, 11 NOT B.
REQ-005 SHALL have port shift, input, 2, applied to B before ALU: 00 none, 01 LSL1, 10 LSR1 (MSB<=0), 11 ASR1 (MSB<=B[15]).
REQ-006 SHALL have ports rn, rm, rd, input, 3 each, source A, source B and destination register numbers.
REQ-007 SHALL have port wb_en, input, 1, 1 = write result to rd, 0 = compare only (status update, no write).
REQ-008 SHALL have port rf_data_out, input, 16, register file read data (combinational from readnum).
REQ-009 SHALL have ports readnum and writenum, output, 3 each, register file read and write selects.
REQ-010 SHALL have port write, output, 1, register file write enable; file writes data_in on rising clk when write=1.
REQ-011 SHALL have port data_in, output, 16, register file write data.
REQ-012 SHALL have ports busy, output, 1 and done, output, 1, busy in any non-IDLE state; done one-cycle completion pulse.
REQ-013 SHALL have ports result, output, 16, register C, and status, output, 3, {V,N,Z}.

Function
REQ-014 SHALL implement states IDLE, RD_A, RD_B, EXEC, WB; encoding is free.
REQ-015 IDLE: start=1 at an edge SHALL capture alu_op, shift, rn, rm, rd, wb_en into internal registers and go to RD_A; start=0 SHALL stay IDLE.
REQ-016 start while busy=1 SHALL be ignored; captured fields SHALL not change until the next IDLE acceptance.
REQ-017 RD_A: readnum=captured rn; on the edge A<=rf_data_out; go to RD_B.
REQ-018 RD_B: readnum=captured rm; on the edge B<=rf_data_out; go to EXEC.
REQ-019 EXEC: on the edge C<=ALU(A, shift(B)) and status<=flags; go to WB.
REQ-020 WB: writenum=captured rd, data_in=C, write=captured wb_en; on the edge go to IDLE and set done=1 for exactly one cycle.
REQ-021 write SHALL be 0 in every state except WB; data_in SHALL equal C in all states.
REQ-022 readnum in IDLE, EXEC and WB SHALL be 000.
REQ-023 Latency: start accepted at edge E0 -> register file written at E4 -> done high during the cycle after E4.
REQ-024 Back-to-back: start=1 during the done cycle SHALL be accepted; throughput one operation per 5 cycles.
REQ-025 Arithmetic SHALL be 16-bit modulo 2^16; carry out discarded.
REQ-026 Z SHALL be 1 iff C==0; N SHALL equal C[15].
REQ-027 V SHALL be signed overflow for ADD (operands same sign, result differs) and SUB (operands differ in sign, result sign differs from A); V SHALL be 0 for AND and NOT.
REQ-028 status SHALL update in EXEC regardless of wb_en; it SHALL hold in all other states.
REQ-029 rd equal to rn or rm SHALL be legal; reads complete before the WB write.
REQ-030 A, B, C and status SHALL hold between operations.

Reset
REQ-031 reset=1 at an edge SHALL force IDLE, A=B=C=0, status=000, done=0, busy=0, write=0, readnum=writenum=000, and clear captured fields, in any state.
REQ-032 reset asserted in WB SHALL take priority: no register file write on that edge, and no done pulse.
REQ-033 start coincident with reset SHALL be ignored.

Verification
REQ-034 Preload R0=5, R1=7; ADD rn=0, rm=1, rd=2, shift=00, wb_en=1 -> R2=12, result=0x000C, status=000, done 4 edges after acceptance.
REQ-035 SUB rn=0, rm=1, rd=3 -> R3=0xFFFE, status N=1, Z=0, V=0.
REQ-036 R4=0x7FFF, R5=0x0001; ADD rd=6 -> R6=0x8000, status V=1, N=1, Z=0.
REQ-037 wb_en=0 SUB rn=1, rm=1, rd=0 -> status Z=1, write never asserted, R0 remains 5.
REQ-038 R1=7, NOT with shift=01, rm=1, rd=7 -> R7=0xFFF1; then ASR1 on B=0x8000 AND 0xFFFF -> 0xC000.
REQ-039 reset pulse during WB of an ADD targeting R2 -> R2 unchanged, done=0, busy=0 next cycle, next start accepted normally.
